// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory bus arbiter.
// Stall bit indices follow the pipeline order {wb,mem,ex,id,if,pc}.
package mem_bus_arbiter_pkg;

  localparam int SEL_WIDTH   = 4;
  localparam int STALL_WIDTH = 6;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [SEL_WIDTH-1:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_IF_BUSY   = 2'd1,
    ST_DATA_BUSY = 2'd2
  } arb_state_t;

  // Stall every stage from PC up to and including stage index 'top'.
  function automatic logic [STALL_WIDTH-1:0] stall_upto(input int top);
    logic [STALL_WIDTH-1:0] r;
    for (int i = 0; i < STALL_WIDTH; i++) r[i] = (i <= top);
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and data
// access, with a request/ack handshake, watchdog abort and pipeline stall output.
//
// state        | meaning
// ST_IDLE      | bus free; grant data first, then fetch
// ST_IF_BUSY   | fetch command on bus, waiting for bus_ack or timeout
// ST_DATA_BUSY | load/store command on bus, waiting for bus_ack or timeout
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   if_req,
  input  logic [ADDR_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0]  if_data,
  output logic                   if_ready,
  input  logic                   data_req,
  input  logic                   data_write,
  input  logic [ADDR_WIDTH-1:0]  data_addr,
  input  logic [DATA_WIDTH-1:0]  data_wdata,
  input  logic [SEL_WIDTH-1:0]   data_sel,
  output logic [DATA_WIDTH-1:0]  data_rdata,
  output logic                   data_ready,
  output logic                   bus_req,
  output logic                   bus_write,
  output logic [ADDR_WIDTH-1:0]  bus_addr,
  output logic [DATA_WIDTH-1:0]  bus_wdata,
  output logic [SEL_WIDTH-1:0]   bus_sel,
  input  logic [DATA_WIDTH-1:0]  bus_rdata,
  input  logic                   bus_ack,
  output logic                   bus_error,
  output logic [STALL_WIDTH-1:0] stall
);

  localparam int CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  arb_state_t            state, state_nxt;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  flush_pend;
  logic                  data_pending, if_pending, busy, expired, done, drop_fetch;
  logic [DATA_WIDTH-1:0] rd_value;

  // A requester whose ready is pulsing this cycle is not re-granted; this
  // produces the single idle cycle between back-to-back grants.
  always_comb begin
    data_pending = data_req && !data_ready;
    if_pending   = if_req && !if_ready;
    busy         = (state != ST_IDLE);
    expired      = (wait_cnt == CNT_LAST);
    done         = busy && (bus_ack || expired);
    rd_value     = bus_ack ? bus_rdata : '0;
    drop_fetch   = flush || flush_pend;
    state_nxt    = state;
    unique case (state)
      ST_IDLE: begin
        if (data_pending)    state_nxt = ST_DATA_BUSY;
        else if (if_pending) state_nxt = ST_IF_BUSY;
      end
      ST_IF_BUSY, ST_DATA_BUSY: begin
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall = '0;
    if (data_pending)    stall = stall_upto(STALL_MEM);
    else if (if_pending) stall = stall_upto(STALL_IF);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_req    <= 1'b0;
      bus_write  <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_sel    <= '0;
      if_data    <= '0;
      data_rdata <= '0;
      if_ready   <= 1'b0;
      data_ready <= 1'b0;
      bus_error  <= 1'b0;
      wait_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if_ready   <= 1'b0;
      data_ready <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          wait_cnt   <= '0;
          flush_pend <= 1'b0;
          if (data_pending) begin
            bus_req   <= 1'b1;
            bus_write <= data_write;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
            bus_sel   <= data_sel;
          end else if (if_pending) begin
            bus_req   <= 1'b1;
            bus_write <= 1'b0;
            bus_addr  <= if_addr;
            bus_sel   <= SEL_WORD;
          end
        end
        ST_IF_BUSY, ST_DATA_BUSY: begin
          if (done) begin
            bus_req    <= 1'b0;
            bus_write  <= 1'b0;
            wait_cnt   <= '0;
            flush_pend <= 1'b0;
            if (!bus_ack) bus_error <= 1'b1;
            // A flushed fetch still finishes on the bus but its result is dropped.
            if (state == ST_IF_BUSY) begin
              if (!drop_fetch) begin
                if_ready <= 1'b1;
                if_data  <= rd_value;
              end
            end else begin
              data_ready <= 1'b1;
              data_rdata <= rd_value;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (state == ST_IF_BUSY && flush) flush_pend <= 1'b1;
          end
        end
        default: begin
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
